// File: rtl/slurm16_cpu_hazard_pipeline_pkg.sv
// Shared CPU definitions: register selector width, special registers, hazard FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package slurm16_cpu_hazard_pipeline_pkg;

  localparam int REGISTER_BITS = 7;

  // Register 0 doubles as "no destination", so a zero stage record never aliases.
  localparam logic [REGISTER_BITS-1:0] R0            = '0;
  localparam logic [REGISTER_BITS-1:0] LINK_REGISTER = REGISTER_BITS'(15);

  typedef enum logic {
    HZ_RUN = 1'b0,
    HZ_HAZ = 1'b1
  } hz_state_t;

endpackage

// File: rtl/slurm16_hazard_stage.sv
// One hazard-record pipeline stage: {destination register, flag-write bit}.
// Latency: 1 cycle from reg_d/flag_d to reg_q/flag_q.
// Backpressure: hold freezes the record; clear (priority over hold) loads an empty record.
//
// Ports: clk, rst_b (sync, active-low), hold, clear, reg_d/flag_d in, reg_q/flag_q out.
module slurm16_hazard_stage #(
  parameter int REGISTER_BITS = slurm16_cpu_hazard_pipeline_pkg::REGISTER_BITS
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     hold,
  input  logic                     clear,
  input  logic [REGISTER_BITS-1:0] reg_d,
  input  logic                     flag_d,
  output logic [REGISTER_BITS-1:0] reg_q,
  output logic                     flag_q
);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      reg_q  <= '0;
      flag_q <= 1'b0;
    end else if (clear) begin
      reg_q  <= '0;
      flag_q <= 1'b0;
    end else if (!hold) begin
      reg_q  <= reg_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/slurm16_cpu_hazard_pipeline.sv
// Hazard-record pipeline p0 -> stages 1..3, stall/bubble control and saturating stall counter.
// Latency: records reach hazard_reg1 one cycle after capture; stall_p0/bubble_p1 are combinational.
// Backpressure: stall_in freezes stages, state and counter; a hazard freezes p0 and bubbles stage 1.
//
// Ports: CLK, RSTb (sync, active-low); p0 record in (hazard_reg0, modifies_flags0);
//   detector verdicts hazard_1/2/3; stall_in, flush; stage records out (hazard_regN,
//   modifies_flagsN, N=1..3); stall_p0, bubble_p1, hazard_state (0 RUN / 1 HAZ), stall_count.
// Option: SLURM16_HAZARD_WB_BYPASS_EN -- register-file write-through covers stage 3,
//   so hazard_3 is ignored.
module slurm16_cpu_hazard_pipeline #(
  parameter int REGISTER_BITS = slurm16_cpu_hazard_pipeline_pkg::REGISTER_BITS,
  parameter int CNT_BITS      = 16
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic [REGISTER_BITS-1:0] hazard_reg0,
  input  logic                     modifies_flags0,
  input  logic                     hazard_1,
  input  logic                     hazard_2,
  input  logic                     hazard_3,
  input  logic                     stall_in,
  input  logic                     flush,
  output logic [REGISTER_BITS-1:0] hazard_reg1,
  output logic [REGISTER_BITS-1:0] hazard_reg2,
  output logic [REGISTER_BITS-1:0] hazard_reg3,
  output logic                     modifies_flags1,
  output logic                     modifies_flags2,
  output logic                     modifies_flags3,
  output logic                     stall_p0,
  output logic                     bubble_p1,
  output logic                     hazard_state,
  output logic [CNT_BITS-1:0]      stall_count
);

  import slurm16_cpu_hazard_pipeline_pkg::*;

  logic      hazard_3_eff;
  logic      haz_any;
  hz_state_t state_q;
  hz_state_t state_d;

`ifdef SLURM16_HAZARD_WB_BYPASS_EN
  // Stage-3 results (registers and flags) are already visible through write-through.
  logic unused_hazard_3;
  assign unused_hazard_3 = hazard_3;
  assign hazard_3_eff    = 1'b0;
`else
  assign hazard_3_eff    = hazard_3;
`endif

  assign haz_any   = hazard_1 | hazard_2 | hazard_3_eff;
  // A flush discards the p0 instruction, so there is nothing left to hold.
  assign stall_p0  = haz_any & ~flush;
  assign bubble_p1 = stall_p0 & ~stall_in;

  // Priority flush > stall_in > hazard > advance, folded into per-stage hold/clear.
  logic clear_s1;
  logic clear_s2;
  assign clear_s1 = flush | (haz_any & ~stall_in);
  assign clear_s2 = flush;

  slurm16_hazard_stage #(.REGISTER_BITS(REGISTER_BITS)) u_stage1 (
    .clk    (CLK),
    .rst_b  (RSTb),
    .hold   (stall_in),
    .clear  (clear_s1),
    .reg_d  (hazard_reg0),
    .flag_d (modifies_flags0),
    .reg_q  (hazard_reg1),
    .flag_q (modifies_flags1)
  );

  slurm16_hazard_stage #(.REGISTER_BITS(REGISTER_BITS)) u_stage2 (
    .clk    (CLK),
    .rst_b  (RSTb),
    .hold   (stall_in),
    .clear  (clear_s2),
    .reg_d  (hazard_reg1),
    .flag_d (modifies_flags1),
    .reg_q  (hazard_reg2),
    .flag_q (modifies_flags2)
  );

  // Stage 3 is past the flush point: on flush it still advances unless memory-stalled.
  slurm16_hazard_stage #(.REGISTER_BITS(REGISTER_BITS)) u_stage3 (
    .clk    (CLK),
    .rst_b  (RSTb),
    .hold   (stall_in),
    .clear  (1'b0),
    .reg_d  (hazard_reg2),
    .flag_d (modifies_flags2),
    .reg_q  (hazard_reg3),
    .flag_q (modifies_flags3)
  );

  // Observability-only state: HAZ while bubbles are being injected.
  always_comb begin
    state_d = state_q;
    if (flush)         state_d = HZ_RUN;
    else if (stall_in) state_d = state_q;
    else if (haz_any)  state_d = HZ_HAZ;
    else               state_d = HZ_RUN;
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) state_q <= HZ_RUN;
    else       state_q <= state_d;
  end

  assign hazard_state = (state_q == HZ_HAZ);

  // Memory-stalled cycles are not charged to the hazard counter.
  always_ff @(posedge CLK) begin
    if (!RSTb)
      stall_count <= '0;
    else if (stall_p0 && !stall_in && (stall_count != {CNT_BITS{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

endmodule
